fetch_unit: RTL

//  Instruction-fetch front end that consumes the branch unit's redirect (branch_taken, pc_wb).

---
 rtl/spu_pkg.sv | 12 +
 rtl/fetch_pair_fifo.sv | 37 +++
 rtl/fetch_unit.sv | 89 ++++++++
 3 files changed

// File: rtl/spu_pkg.sv
// spu_pkg: shared fetch types and widths for the SPU front end.
package spu_pkg;
  localparam int PC_W = 8;
  localparam int INSTR_W = 32;
  typedef struct packed {
    logic [INSTR_W-1:0] instr0;
    logic [INSTR_W-1:0] instr1;
    logic               slot0_valid;
    logic [PC_W-1:0]    pc;
  } fetch_pair_t;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} fetch_state_e;
endpackage

// File: rtl/fetch_pair_fifo.sv
// fetch_pair_fifo: DEPTH-entry pair buffer; flush wins over push, head is zero when empty.
module fetch_pair_fifo import spu_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  fetch_pair_t din,
  output fetch_pair_t head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);
  fetch_pair_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (reset && !flush && do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, credit-limited pair fetch and epoch-tagged redirect; FETCH_PERF_CNT_EN adds perf counters.
module fetch_unit import spu_pkg::*; #(
  parameter int PC_W = spu_pkg::PC_W,
  parameter int DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_rd_en,
  output logic [PC_W-2:0]      imem_addr,
  input  logic [2*INSTR_W-1:0] imem_data,
  input  logic                 branch_taken,
  input  logic [PC_W-1:0]      pc_wb,
  output logic                 pair_valid,
  input  logic                 pair_ready,
  output logic [INSTR_W-1:0]   instr0,
  output logic [INSTR_W-1:0]   instr1,
  output logic                 slot0_valid,
  output logic [PC_W-1:0]      pair_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]          perf_redirects,
  output logic [15:0]          perf_stall_cycles
`endif
);
  fetch_state_e state;
  logic [PC_W-1:0] fetch_pc, ret_pc;
  logic epoch, ret_epoch, ret_v, ret_odd, first_odd;
  logic live, pop, full, empty, credit_ok;
  logic [$clog2(DEPTH):0] count;
  fetch_pair_t din, head;
  // A return only counts (for push and credits) if issued in the current epoch.
  assign live = ret_v && ret_epoch == epoch;
  assign pop = pair_valid && pair_ready;
  assign credit_ok = !full && (int'(count) + int'(live) < DEPTH);
  assign imem_rd_en = state == FETCH && credit_ok;
  assign imem_addr = fetch_pc[PC_W-1:1];
  assign din = '{instr0: imem_data[INSTR_W-1:0], instr1: imem_data[2*INSTR_W-1:INSTR_W],
                 slot0_valid: !ret_odd, pc: ret_pc};
  assign pair_valid = !empty;
  assign instr0 = head.instr0;
  assign instr1 = head.instr1;
  assign slot0_valid = head.slot0_valid;
  assign pair_pc = head.pc;
  fetch_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(live), .pop(pop), .flush(branch_taken),
    .din(din), .head(head), .full(full), .empty(empty), .count(count)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      state     <= IDLE;
      fetch_pc  <= {RESET_PC[PC_W-1:1], 1'b0};
      first_odd <= RESET_PC[0];
      epoch     <= 1'b0;
      ret_v     <= 1'b0;
      ret_epoch <= 1'b0;
      ret_pc    <= '0;
      ret_odd   <= 1'b0;
    end else begin
      ret_v     <= imem_rd_en;
      ret_epoch <= epoch;
      ret_pc    <= fetch_pc;
      ret_odd   <= first_odd;
      if (branch_taken) begin
        state     <= FETCH;
        epoch     <= !epoch;
        fetch_pc  <= {pc_wb[PC_W-1:1], 1'b0};
        first_odd <= pc_wb[0];
      end else begin
        if (imem_rd_en) begin
          fetch_pc  <= fetch_pc + PC_W'(2);
          first_odd <= 1'b0;
        end
        state <= state == IDLE ? FETCH :
                 state == FETCH ? (credit_ok ? FETCH : HOLD) :
                 (pop || credit_ok) ? FETCH : HOLD;
      end
    end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk)
    if (!reset) begin
      perf_redirects    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (branch_taken && perf_redirects != 16'hFFFF) perf_redirects <= perf_redirects + 1'b1;
      if (!pair_valid && perf_stall_cycles != 16'hFFFF) perf_stall_cycles <= perf_stall_cycles + 1'b1;
    end
`endif
endmodule
